// File: rtl/xpb_table_gen.sv
// xpb_table_gen: builds T[j] = j*B mod N by repeated modular addition, then serves parallel registered lookups
module xpb_table_gen #(
  parameter int IDX_BITS   = 5,
  parameter int WORD_BITS  = 1024,
  parameter int NUM_LOOKUP = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [WORD_BITS-1:0]            cfg_base,
  input  logic [WORD_BITS-1:0]            cfg_mod,
  output logic                            busy,
  output logic                            table_ready,
  input  logic [NUM_LOOKUP-1:0]           lk_valid,
  input  logic [NUM_LOOKUP*IDX_BITS-1:0]  lk_idx,
  output logic [NUM_LOOKUP-1:0]           lk_out_valid,
  output logic [NUM_LOOKUP*WORD_BITS-1:0] lk_data
);
  localparam int DEPTH = 1 << IDX_BITS;
  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;
  state_t               r_state;
  logic [WORD_BITS-1:0] r_n, r_b, r_acc;
  logic [IDX_BITS-1:0]  r_cnt;
  logic [WORD_BITS-1:0] r_mem [DEPTH];
  logic                 w_accept;
  logic [WORD_BITS:0]   w_sum;
  logic [WORD_BITS-1:0] w_bred, w_next;
  assign w_accept = cfg_valid & cfg_ready;
  assign w_bred   = (cfg_base >= cfg_mod) ? cfg_base - cfg_mod : cfg_base;
  // one extra bit so acc + B' cannot overflow before the conditional subtract
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_b};
  assign w_next   = WORD_BITS'((w_sum >= {1'b0, r_n}) ? w_sum - {1'b0, r_n} : w_sum);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      table_ready <= 1'b0;
      r_n         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_state     <= FILL;
      cfg_ready   <= 1'b0;
      busy        <= 1'b1;
      table_ready <= 1'b0;
      r_n         <= cfg_mod;
      r_b         <= w_bred;
      r_acc       <= w_bred;
      r_cnt       <= IDX_BITS'(1);
    end else if (r_state == FILL) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '1) begin
        r_state     <= READY;
        cfg_ready   <= 1'b1;
        busy        <= 1'b0;
        table_ready <= 1'b1;
      end
    end
  end
  // accept and fill are mutually exclusive, so one write port covers both
  always_ff @(posedge clk)
    if (!rst && (w_accept || busy)) r_mem[busy ? r_cnt : '0] <= busy ? r_acc : '0;
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LOOKUP; i++) begin
      if (rst) begin
        lk_out_valid[i]                   <= 1'b0;
        lk_data[i*WORD_BITS +: WORD_BITS] <= '0;
      end else begin
        lk_out_valid[i] <= lk_valid[i] & table_ready;
        if (lk_valid[i] & table_ready)
          lk_data[i*WORD_BITS +: WORD_BITS] <= r_mem[lk_idx[i*IDX_BITS +: IDX_BITS]];
      end
    end
  end
endmodule

// File: tb/tb_xpb_table_gen.sv
// tb_xpb_table_gen: directed checks of fill, lookup, reconfigure and reset on a 16-bit and a 1024-bit instance
module tb_xpb_table_gen;
  localparam int IB = 5, W = 16, WW = 1024;
  logic            clk = 1'b0, rst;
  logic            cfg_valid, cfg_ready, busy, table_ready;
  logic [W-1:0]    cfg_base, cfg_mod;
  logic [1:0]      lk_valid, lk_out_valid;
  logic [2*IB-1:0] lk_idx;
  logic [2*W-1:0]  lk_data;
  logic            wcfg_valid, wcfg_ready, wbusy, wtable_ready;
  logic [WW-1:0]   wcfg_base, wcfg_mod;
  logic [1:0]      wlk_valid, wlk_out_valid;
  logic [2*IB-1:0] wlk_idx;
  logic [2*WW-1:0] wlk_data;
  logic [WW-1:0]   wexp [32];
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  xpb_table_gen #(.IDX_BITS(IB), .WORD_BITS(W), .NUM_LOOKUP(2)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base(cfg_base), .cfg_mod(cfg_mod), .busy(busy), .table_ready(table_ready),
    .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_out_valid(lk_out_valid), .lk_data(lk_data));

  xpb_table_gen #(.IDX_BITS(IB), .WORD_BITS(WW), .NUM_LOOKUP(2)) u_wide (
    .clk(clk), .rst(rst), .cfg_valid(wcfg_valid), .cfg_ready(wcfg_ready),
    .cfg_base(wcfg_base), .cfg_mod(wcfg_mod), .busy(wbusy), .table_ready(wtable_ready),
    .lk_valid(wlk_valid), .lk_idx(wlk_idx), .lk_out_valid(wlk_out_valid), .lk_data(wlk_data));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [W-1:0] b, input logic [W-1:0] n);
    cfg_base = b; cfg_mod = n; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic look(input int a, input int b);
    lk_valid = 2'b11; lk_idx = {5'(b), 5'(a)};
    tick();
    lk_valid = 2'b00;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!table_ready && n < 100) begin tick(); n++; end
  endtask

  function automatic logic [W-1:0] xpb(input int j, input logic [W-1:0] b, input logic [W-1:0] n);
    logic [31:0] bp;
    bp = (b >= n) ? 32'(b - n) : 32'(b);
    return W'((32'(j) * bp) % 32'(n));
  endfunction

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_base = '0; cfg_mod = '0; lk_valid = '0; lk_idx = '0;
    wcfg_valid = 1'b0; wcfg_base = '0; wcfg_mod = '0; wlk_valid = '0; wlk_idx = '0;
    repeat (3) tick();
    rst = 1'b0; lk_valid = 2'b11; lk_idx = '1;
    tick(); tick();
    total++; if (lk_out_valid !== 2'b00) $display("FAIL reset_lk_out_valid got %b exp 00", lk_out_valid); else passed++;
    total++; if (lk_data !== '0) $display("FAIL reset_lk_data got %h exp 0", lk_data); else passed++;
    total++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); else passed++;
    total++; if (table_ready !== 1'b0) $display("FAIL reset_table_ready got %b exp 0", table_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    lk_valid = 2'b00;
  endtask

  task automatic test_fill();
    int n;
    cfg(16'h0064, 16'h00FB);
    total++; if (busy !== 1'b1) $display("FAIL fill_busy got %b exp 1", busy); else passed++;
    total++; if (cfg_ready !== 1'b0) $display("FAIL fill_cfg_ready got %b exp 0", cfg_ready); else passed++;
    wait_ready(n);
    total++; if (n !== 31) $display("FAIL fill_latency got %0d exp 31", n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL fill_busy_end got %b exp 0", busy); else passed++;
    look(0, 1);
    total++; if (lk_data !== {16'h0064, 16'h0000}) $display("FAIL fill_t0_t1 got %h exp 00640000", lk_data); else passed++;
    look(2, 3);
    total++; if (lk_data !== {16'h0031, 16'h00C8}) $display("FAIL fill_t2_t3 got %h exp 003100c8", lk_data); else passed++;
  endtask

  task automatic test_lookup();
    look(3, 31);
    total++; if (lk_out_valid !== 2'b11) $display("FAIL lk_valid_pair got %b exp 11", lk_out_valid); else passed++;
    total++; if (lk_data !== {16'h0058, 16'h0031}) $display("FAIL lk_3_31 got %h exp 00580031", lk_data); else passed++;
    look(7, 7);
    total++; if (lk_data !== {16'h00C6, 16'h00C6}) $display("FAIL lk_same_idx got %h exp 00c600c6", lk_data); else passed++;
    lk_valid = 2'b01; lk_idx = {5'd0, 5'd1};
    tick();
    lk_valid = 2'b00;
    total++; if (lk_out_valid !== 2'b01) $display("FAIL lk_single_valid got %b exp 01", lk_out_valid); else passed++;
    total++; if (lk_data !== {16'h00C6, 16'h0064}) $display("FAIL lk_single_hold got %h exp 00c60064", lk_data); else passed++;
    tick();
    total++; if (lk_out_valid !== 2'b00) $display("FAIL lk_idle_valid got %b exp 00", lk_out_valid); else passed++;
  endtask

  task automatic test_reconfig();
    int n;
    cfg_base = 16'h0064; cfg_mod = 16'h00FB; cfg_valid = 1'b1;
    tick();
    cfg_base = 16'h0777;
    n = 0;
    while (!table_ready && n < 100) begin tick(); n++; end
    cfg_valid = 1'b0;
    total++; if (n !== 31) $display("FAIL rc_ignore_latency got %0d exp 31", n); else passed++;
    look(31, 1);
    total++; if (lk_data !== {16'h0064, 16'h0058}) $display("FAIL rc_ignore_table got %h exp 00640058", lk_data); else passed++;
    cfg_base = 16'h0100; cfg_mod = 16'h00FB; cfg_valid = 1'b1;
    lk_valid = 2'b11; lk_idx = {5'd2, 5'd31};
    tick();
    cfg_valid = 1'b0;
    total++; if (lk_out_valid !== 2'b11) $display("FAIL rc_accept_lk_valid got %b exp 11", lk_out_valid); else passed++;
    total++; if (lk_data !== {16'h00C8, 16'h0058}) $display("FAIL rc_accept_old_data got %h exp 00c80058", lk_data); else passed++;
    total++; if (table_ready !== 1'b0) $display("FAIL rc_table_ready_drop got %b exp 0", table_ready); else passed++;
    tick();
    lk_valid = 2'b00;
    total++; if (lk_out_valid !== 2'b00) $display("FAIL rc_drop_valid got %b exp 00", lk_out_valid); else passed++;
    total++; if (lk_data !== {16'h00C8, 16'h0058}) $display("FAIL rc_drop_hold got %h exp 00c80058", lk_data); else passed++;
    wait_ready(n);
    total++; if (n !== 30) $display("FAIL rc_latency got %0d exp 30", n); else passed++;
    look(31, 1);
    total++; if (lk_data !== {16'h0005, 16'h009B}) $display("FAIL rc_new_table got %h exp 0005009b", lk_data); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int n;
    cfg(16'h0123, 16'h01F3);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (table_ready !== 1'b0) $display("FAIL rmf_table_ready got %b exp 0", table_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rmf_busy got %b exp 0", busy); else passed++;
    total++; if (cfg_ready !== 1'b1) $display("FAIL rmf_cfg_ready got %b exp 1", cfg_ready); else passed++;
    look(5, 6);
    total++; if (lk_out_valid !== 2'b00) $display("FAIL rmf_lk_dropped got %b exp 00", lk_out_valid); else passed++;
    total++; if (lk_data !== '0) $display("FAIL rmf_lk_data got %h exp 0", lk_data); else passed++;
    cfg(16'hC123, 16'h7001);
    wait_ready(n);
    total++; if (n !== 31) $display("FAIL rmf_latency got %0d exp 31", n); else passed++;
    for (int j = 0; j < 32; j += 2) begin
      look(j, j + 1);
      total++; if (lk_data[15:0] !== xpb(j, 16'hC123, 16'h7001))
        $display("FAIL rmf_T%0d got %h exp %h", j, lk_data[15:0], xpb(j, 16'hC123, 16'h7001)); else passed++;
      total++; if (lk_data[31:16] !== xpb(j + 1, 16'hC123, 16'h7001))
        $display("FAIL rmf_T%0d got %h exp %h", j + 1, lk_data[31:16], xpb(j + 1, 16'hC123, 16'h7001)); else passed++;
    end
  endtask

  task automatic test_wide();
    logic [WW-1:0]   n, b;
    logic [WW+31:0]  p;
    int              c, a, bb;
    for (int k = 0; k < WW / 32; k++) n[k*32 +: 32] = $urandom;
    n[WW-1] = 1'b1;
    for (int k = 0; k < WW / 32; k++) b[k*32 +: 32] = $urandom;
    b = b % n;
    for (int j = 0; j < 32; j++) begin
      p = (WW + 32)'(j) * {32'b0, b};
      p = p % {32'b0, n};
      wexp[j] = p[WW-1:0];
    end
    wcfg_base = b; wcfg_mod = n; wcfg_valid = 1'b1;
    tick();
    wcfg_valid = 1'b0;
    c = 0;
    while (!wtable_ready && c < 100) begin tick(); c++; end
    total++; if (c !== 31) $display("FAIL wide_latency got %0d exp 31", c); else passed++;
    wlk_valid = 2'b11;
    for (int j = 0; j < 32; j += 2) begin
      wlk_idx = {5'(j + 1), 5'(j)};
      tick();
      total++; if (wlk_data[WW-1:0] !== wexp[j]) $display("FAIL wide_T%0d low word got %h exp %h", j, wlk_data[31:0], wexp[j][31:0]); else passed++;
      total++; if (wlk_data[2*WW-1:WW] !== wexp[j+1]) $display("FAIL wide_T%0d low word got %h exp %h", j + 1, wlk_data[WW+31:WW], wexp[j+1][31:0]); else passed++;
    end
    for (int k = 0; k < 1000; k++) begin
      a = int'($urandom_range(0, 31)); bb = int'($urandom_range(0, 31));
      wlk_idx = {5'(bb), 5'(a)};
      tick();
      total++; if (wlk_out_valid !== 2'b11) $display("FAIL wide_b2b_valid cyc %0d got %b exp 11", k, wlk_out_valid); else passed++;
      total++; if (wlk_data[WW-1:0] !== wexp[a]) $display("FAIL wide_b2b_p0 cyc %0d idx %0d low word got %h exp %h", k, a, wlk_data[31:0], wexp[a][31:0]); else passed++;
      total++; if (wlk_data[2*WW-1:WW] !== wexp[bb]) $display("FAIL wide_b2b_p1 cyc %0d idx %0d low word got %h exp %h", k, bb, wlk_data[WW+31:WW], wexp[bb][31:0]); else passed++;
    end
    wlk_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lookup();
    test_reconfig();
    test_reset_mid_fill();
    test_wide();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d of %0d checks", passed, total);
    $fatal(1);
  end
endmodule
